// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the load/store front end.
//   - funct3 encodings for loads and stores
//   - FSM state type
//   - helpers that classify a request (supported / misaligned)
//   - default RAM byte-address width

`ifndef RAM_ADDRESS_BITWIDTH
`define RAM_ADDRESS_BITWIDTH 16
`endif

package mem_pkg;

    localparam int RAM_ADDR_W_DEFAULT = `RAM_ADDRESS_BITWIDTH;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } mem_state_t;

    // Access size lives in funct3[1:0] for both loads and stores, so the
    // alignment rule does not need to know the direction.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic is_supported(input logic       is_store,
                                          input logic [2:0] funct3);
        logic ok;
        if (is_store) begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational little-endian lane handling.
// Ports:
//   funct3_i    access type (RISC-V funct3)
//   addr_lo_i   byte offset within the word
//   rdata_i     word read from RAM
//   wdata_lo_i  low halfword of the store data (SB uses [7:0])
//   load_o      selected and extended load result
//   merge_o     rdata_i with the store byte/halfword inserted at its lane

module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    input  logic [15:0] wdata_lo_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] ins;

    // Byte lane N occupies bits [8N+7:8N]; halfwords sit at lane 0 or 2.
    assign shamt   = {addr_lo_i, 3'b000};
    assign shifted = rdata_i >> shamt;

    always_comb begin
        load_o = '0;
        case (funct3_i)
            F3_B:    load_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    load_o = rdata_i;
            F3_BU:   load_o = {24'd0, shifted[7:0]};
            F3_HU:   load_o = {16'd0, shifted[15:0]};
            default: load_o = '0;
        endcase
    end

    always_comb begin
        mask = '0;
        ins  = '0;
        case (funct3_i[1:0])
            2'b00: begin
                mask = 32'h0000_00FF << shamt;
                ins  = {24'd0, wdata_lo_i[7:0]} << shamt;
            end
            2'b01: begin
                mask = 32'h0000_FFFF << {addr_lo_i[1], 4'b0000};
                ins  = {16'd0, wdata_lo_i} << {addr_lo_i[1], 4'b0000};
            end
            default: begin
                mask = '0;
                ins  = '0;
            end
        endcase
        merge_o = (rdata_i & ~mask) | ins;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end driving a synchronous-read data RAM.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_*_i / req_ready_o    request channel (one outstanding request)
//   resp_valid_o/data/exc    one-cycle response pulse, no backpressure
//   ram_we_o/address/wdata   RAM write/address/data, decoded from state
//   ram_rdata_i              RAM read data, valid the cycle after address
//   dbg_state_o              current FSM state (mem_state_t encoding)
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high. req_ready_o is high only in IDLE, so at most one
// request is in flight; req_valid_i while busy is ignored. resp_valid_o is a
// single-cycle pulse that the consumer must take.

module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_exc,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [2:0]        dbg_state_o
);

    mem_state_t        state_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [31:0]       resp_data_q;
    logic              resp_exc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [31:0]       wdata_q;
    logic              is_store_q;
    logic [31:0]       merge_q;

    logic              accept;
    logic              req_exc;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;
    logic [ADDR_W-1:0] word_addr;

    // Address bits above the RAM width wrap silently.
    generate
        if (ADDR_W < 32) begin : g_addr_trunc
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[31:ADDR_W];
        end
    endgenerate

    assign accept  = req_valid && req_ready_q;
    assign req_exc = !is_supported(req_is_store, req_funct3) ||
                     is_misaligned(req_funct3, req_addr[1:0]);

    mem_lane_align u_lane_align (
        .funct3_i   (funct3_q),
        .addr_lo_i  (addr_q[1:0]),
        .rdata_i    (ram_rdata),
        .wdata_lo_i (wdata_q[15:0]),
        .load_o     (load_data),
        .merge_o    (merge_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_exc_q   <= 1'b0;
            addr_q       <= '0;
            funct3_q     <= '0;
            wdata_q      <= '0;
            is_store_q   <= 1'b0;
            merge_q      <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Ready rises one cycle after reset release; later
                    // visits to IDLE arrive with ready already set by RESP.
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr[ADDR_W-1:0];
                        funct3_q    <= req_funct3;
                        wdata_q     <= req_wdata;
                        is_store_q  <= req_is_store;
                        resp_data_q <= '0;
                        resp_exc_q  <= req_exc;
                        if (req_exc) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end else if (req_is_store && (req_funct3 == F3_W)) begin
                            state_q <= WR;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    state_q <= RD_DATA;
                end
                RD_DATA: begin
                    if (is_store_q) begin
                        merge_q <= merge_data;
                        state_q <= WR;
                    end else begin
                        resp_data_q  <= load_data;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                WR: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // RAM controls decode from state only, so an asynchronous reset during
    // WR removes ram_we before the next edge and the RAM is left untouched.
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        ram_we      = 1'b0;
        ram_address = '0;
        ram_wdata   = '0;
        case (state_q)
            RD: begin
                ram_address = word_addr;
            end
            WR: begin
                ram_we      = 1'b1;
                ram_address = word_addr;
                ram_wdata   = (funct3_q == F3_W) ? wdata_q : merge_q;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_exc    = resp_exc_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int ADDR_W = 16;
  localparam int WORDS  = 1 << (ADDR_W - 2);

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_exc;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [2:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic        exc_q[$];
  int          lat_q[$];

  // RAM model: synchronous read, write on ram_we
  logic [31:0] mem [WORDS];
  int          wr_cnt = 0;
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_exc     (resp_exc),
    .ram_we       (ram_we),
    .ram_address  (ram_address),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_address[ADDR_W-1:2]] <= ram_wdata;
      wr_cnt = wr_cnt + 1;
      last_wr_addr = 32'(ram_address);
      last_wr_data = ram_wdata;
    end
    ram_rdata <= mem[ram_address[ADDR_W-1:2]];
  end

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lo +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  // driver: issue one request, wait for accept and response (bounded)
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] d, output logic e,
                       output int lat);
    bit acc;
    acc = 0;
    d   = '0;
    e   = 1'b0;
    lat = -1;
    @(negedge clk);
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    req_valid    = 1'b1;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(posedge clk);
      if (req_ready) acc = 1;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout addr=%08h got no accept, required accept within 20 cycles", a);
      req_valid = 1'b0;
      return;
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (resp_valid) begin
        lat = k;
        d   = resp_data;
        e   = resp_exc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_exc, ram_we} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got ready/valid/exc/we=%b required 0000",
               {req_ready, resp_valid, resp_exc, ram_we});
    end
    checks++;
    if (resp_data !== 32'd0) begin
      errors++; $display("FAIL reset_resp_data got %08h required 00000000", resp_data);
    end
    checks++;
    if (ram_address !== '0 || ram_wdata !== 32'd0) begin
      errors++; $display("FAIL reset_ram got addr=%h wdata=%08h required 0/0", ram_address, ram_wdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b required 1", req_ready);
    end
  endtask

  task automatic check_resp(input string name, input logic [31:0] d, input logic e, input int lat);
    logic [31:0] ed;
    logic        ee;
    int          el;
    ed = exp_q.pop_front();
    ee = exc_q.pop_front();
    el = lat_q.pop_front();
    checks++;
    if (d !== ed) begin
      errors++; $display("FAIL %s_data got %08h required %08h", name, d, ed);
    end
    checks++;
    if (e !== ee) begin
      errors++; $display("FAIL %s_exc got %b required %b", name, e, ee);
    end
    checks++;
    if (lat != el) begin
      errors++; $display("FAIL %s_latency got %0d required %0d", name, lat, el);
    end
  endtask

  task automatic test_store_word();
    logic [31:0] d; logic e; int lat; int w0;
    w0 = wr_cnt;
    exp_q.push_back(32'd0); exc_q.push_back(1'b0); lat_q.push_back(2);
    issue(1'b1, F3_W, 32'h100, 32'h882233F4, d, e, lat);
    check_resp("sw", d, e, lat);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL sw_pulse_width got resp_valid=%b required 0", resp_valid);
    end
    checks++;
    if (wr_cnt - w0 != 1 || last_wr_addr !== 32'h100 || last_wr_data !== 32'h882233F4) begin
      errors++;
      $display("FAIL sw_ram_write got writes=%0d addr=%08h data=%08h required 1/00000100/882233f4",
               wr_cnt - w0, last_wr_addr, last_wr_data);
    end
    exp_q.push_back(32'h882233F4); exc_q.push_back(1'b0); lat_q.push_back(3);
    issue(1'b0, F3_W, 32'h100, 32'h0, d, e, lat);
    check_resp("lw", d, e, lat);
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s [5] = '{F3_B, F3_BU, F3_H, F3_HU, F3_B};
    logic [31:0] ads [5] = '{32'h100, 32'h100, 32'h102, 32'h102, 32'h103};
    logic [31:0] exs [5] = '{32'hFFFFFFF4, 32'h000000F4, 32'hFFFF8822, 32'h00008822, 32'hFFFFFF88};
    logic [31:0] d; logic e; int lat;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(exs[i]); exc_q.push_back(1'b0); lat_q.push_back(3);
      issue(1'b0, f3s[i], ads[i], 32'h0, d, e, lat);
      check_resp("load_ext", d, e, lat);
    end
  endtask

  task automatic test_subword_store();
    logic [31:0] d; logic e; int lat;
    exp_q.push_back(32'd0); exc_q.push_back(1'b0); lat_q.push_back(4);
    issue(1'b1, F3_B, 32'h101, 32'h123456AB, d, e, lat);
    check_resp("sb", d, e, lat);
    checks++;
    if (last_wr_data !== 32'h8822ABF4 || last_wr_addr !== 32'h100) begin
      errors++; $display("FAIL sb_merge got %08h@%08h required 8822abf4@00000100", last_wr_data, last_wr_addr);
    end
    exp_q.push_back(32'd0); exc_q.push_back(1'b0); lat_q.push_back(4);
    issue(1'b1, F3_H, 32'h102, 32'h0000BEEF, d, e, lat);
    check_resp("sh", d, e, lat);
    checks++;
    if (last_wr_data !== 32'hBEEFABF4) begin
      errors++; $display("FAIL sh_merge got %08h required beefabf4", last_wr_data);
    end
    exp_q.push_back(32'hBEEFABF4); exc_q.push_back(1'b0); lat_q.push_back(3);
    issue(1'b0, F3_W, 32'h100, 32'h0, d, e, lat);
    check_resp("lw_after_rmw", d, e, lat);
  endtask

  task automatic test_exceptions();
    logic        sts [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [5] = '{F3_W, F3_H, 3'b011, 3'b100, F3_HU};
    logic [31:0] ads [5] = '{32'h102, 32'h101, 32'h100, 32'h100, 32'h103};
    logic [31:0] d; logic e; int lat; int w0;
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(32'd0); exc_q.push_back(1'b1); lat_q.push_back(1);
      issue(sts[i], f3s[i], ads[i], 32'hDEADBEEF, d, e, lat);
      check_resp("exc", d, e, lat);
    end
    checks++;
    if (wr_cnt != w0) begin
      errors++; $display("FAIL exc_no_write got %0d writes required 0", wr_cnt - w0);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d; logic e; int lat;
    exp_q.push_back(32'hBEEFABF4); exc_q.push_back(1'b0); lat_q.push_back(3);
    issue(1'b0, F3_W, 32'h0001_0100, 32'h0, d, e, lat);
    check_resp("wrap", d, e, lat);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int lat; int w0;
    bit acc;
    w0  = wr_cnt;
    acc = 0;
    @(negedge clk);
    req_is_store = 1'b1; req_funct3 = F3_B; req_addr = 32'h100; req_wdata = 32'h00000055;
    req_valid = 1'b1;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(posedge clk);
      if (req_ready) acc = 1;
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== 3'(RD_DATA)) begin
      errors++; $display("FAIL midrst_state got %0d required %0d", dbg_state, 3'(RD_DATA));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, resp_valid, ram_we} !== 3'b000 || ram_address !== '0 || ram_wdata !== 32'd0 ||
        dbg_state !== 3'(IDLE)) begin
      errors++;
      $display("FAIL midrst_outputs got ready/valid/we=%b addr=%h wdata=%08h state=%0d required 000/0/0/0",
               {req_ready, resp_valid, ram_we}, ram_address, ram_wdata, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_ready_at_release got %b required 0", req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_ready_after got %b required 1", req_ready);
    end
    checks++;
    if (wr_cnt != w0) begin
      errors++; $display("FAIL midrst_no_write got %0d writes required 0", wr_cnt - w0);
    end
    exp_q.push_back(32'hBEEFABF4); exc_q.push_back(1'b0); lat_q.push_back(3);
    issue(1'b0, F3_W, 32'h100, 32'h0, d, e, lat);
    check_resp("midrst_word", d, e, lat);
  endtask

  task automatic test_back_to_back();
    localparam int N = 8;
    logic [2:0]  f3s [N];
    logic [31:0] ads [N];
    logic [2:0]  kinds [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [31:0] got_d;
    logic [31:0] exp_d;
    int idx, got, cyc, last_acc;
    for (int i = 0; i < N; i++) begin
      mem[32'h80 + i] = $urandom;
      f3s[i] = kinds[$urandom_range(0, 4)];
      ads[i] = 32'h200 + 32'(4 * i);
      if (f3s[i][1:0] == 2'b00) ads[i][1:0] = 2'($urandom_range(0, 3));
      else if (f3s[i][1:0] == 2'b01) ads[i][1] = 1'($urandom_range(0, 1));
    end
    idx = 0; got = 0; cyc = 0; last_acc = -1;
    @(negedge clk);
    req_is_store = 1'b0; req_funct3 = f3s[0]; req_addr = ads[0]; req_valid = 1'b1;
    while (got < N && cyc < 200) begin
      @(posedge clk);
      cyc++;
      if (req_valid && req_ready) begin
        exp_q.push_back(model_load(mem[32'h80 + idx], f3s[idx], ads[idx][1:0]));
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 4) begin
            errors++; $display("FAIL b2b_accept_gap got %0d required 4", cyc - last_acc);
          end
        end
        last_acc = cyc;
        idx++;
      end
      @(negedge clk);
      if (dbg_state == 3'(RD) || dbg_state == 3'(RD_DATA) || dbg_state == 3'(RESP)) begin
        checks++;
        if (req_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_ready_busy got %b in state %0d required 0", req_ready, dbg_state);
        end
      end
      if (resp_valid) begin
        got_d = resp_data;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_resp got data %08h required no response", got_d);
        end else begin
          exp_d = exp_q.pop_front();
          if (got_d !== exp_d || resp_exc !== 1'b0) begin
            errors++; $display("FAIL b2b_data got %08h exc=%b required %08h exc=0", got_d, resp_exc, exp_d);
          end
        end
        got++;
      end
      if (idx < N) begin
        req_funct3 = f3s[idx]; req_addr = ads[idx];
      end else begin
        req_valid = 1'b0;
      end
    end
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_duplicate got resp_valid=1 required 0");
      end
    end
    checks++;
    if (idx != N || got != N || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_count got accepted=%0d responses=%0d pending=%0d required %0d/%0d/0",
                         idx, got, exp_q.size(), N, N);
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = 32'd0;
    test_reset();
    test_store_word();
    test_load_ext();
    test_subword_store();
    test_exceptions();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
